// File: rtl/poco_mc_if.sv
// rtl/poco_mc_if.sv - instruction and data bus bundle between the poco_mc core and memory
interface poco_mc_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] iaddr;
  logic              ireq;
  logic              iack;
  logic [15:0]       idatain;
  logic [DATA_W-1:0] daddr;
  logic [DATA_W-1:0] ddataout;
  logic              dreq;
  logic              dwe;
  logic              dack;
  logic [DATA_W-1:0] ddatain;

  modport master (
    output iaddr, ireq, daddr, ddataout, dreq, dwe,
    input  iack, idatain, dack, ddatain
  );

  modport slave (
    input  iaddr, ireq, daddr, ddataout, dreq, dwe,
    output iack, idatain, dack, ddatain
  );
endinterface

// File: rtl/poco_mc.sv
// rtl/poco_mc.sv - POCO_MC multi-cycle core (FETCH/EXEC/MEM); define POCO_MC_JAL_EN to add JAL/JALR
module poco_mc #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  poco_mc_if.master bus,
  output logic      retire
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_exec;
  logic [15:0]       ir;
  logic              ireq_q;
  logic              dreq_q;
  logic              dwe_q;
  logic [DATA_W-1:0] daddr_q;
  logic [DATA_W-1:0] ddataout_q;
  logic [DATA_W-1:0] rf [8];

  logic [4:0]        opcode;
  logic [4:0]        func;
  logic [2:0]        rd_idx;
  logic [2:0]        rs_idx;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] sext_imm;
  logic [DATA_W-1:0] zext_imm;
  logic [DATA_W-1:0] hi_imm;
  logic [DATA_W-1:0] sext_off;
  logic [DATA_W-1:0] alu_y;
  logic              wb_en;
  logic [2:0]        wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              mem_go;
  logic              mem_we;

  assign opcode   = ir[15:11];
  assign rd_idx   = ir[10:8];
  assign rs_idx   = ir[7:5];
  assign func     = ir[4:0];
  assign sext_imm = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign zext_imm = DATA_W'(ir[7:0]);
  assign hi_imm   = DATA_W'({ir[7:0], 8'h00});
  assign sext_off = {{(DATA_W-11){ir[10]}}, ir[10:0]};

  // Registers beyond RF_DEPTH do not exist and read as zero
  assign a = (int'(rd_idx) < RF_DEPTH) ? rf[rd_idx] : '0;
  assign b = (int'(rs_idx) < RF_DEPTH) ? rf[rs_idx] : '0;

  assign bus.iaddr    = pc;
  assign bus.ireq     = ireq_q;
  assign bus.daddr    = daddr_q;
  assign bus.ddataout = ddataout_q;
  assign bus.dreq     = dreq_q;
  assign bus.dwe      = dwe_q;

  // Register-register ALU; the reserved select behaves as a move
  always_comb begin
    alu_y = b;
    case (func[2:0])
      3'b010:  alu_y = a | b;
      3'b011:  alu_y = a & b;
      3'b100:  alu_y = a << 1;
      3'b101:  alu_y = a >> 1;
      3'b110:  alu_y = a + b;
      3'b111:  alu_y = a - b;
      default: alu_y = b;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // Next state, decode, register write-back and next pc; pc is already incremented in EXEC
  always_comb begin
    state_nx = state;
    wb_en    = 1'b0;
    wb_idx   = rd_idx;
    wb_data  = '0;
    pc_exec  = pc;
    mem_go   = 1'b0;
    mem_we   = 1'b0;
    case (state)
      FETCH: begin
        if (bus.iack) state_nx = EXEC;
      end
      EXEC: begin
        state_nx = FETCH;
        case (opcode)
          5'b00000: begin
            if (func[4:3] == 2'b00) begin
              wb_en   = 1'b1;
              wb_data = alu_y;
            end else if (func == 5'b01000 || func == 5'b01001) begin
              mem_go   = 1'b1;
              mem_we   = ~func[0];
              state_nx = MEM;
            end else if (func == 5'b01100) begin
              pc_exec = a;
`ifdef POCO_MC_JAL_EN
            end else if (func == 5'b11000) begin
              pc_exec = a;
              wb_en   = 1'b1;
              wb_idx  = 3'd7;
              wb_data = pc;
`endif
            end
          end
          5'b01000: begin wb_en = 1'b1; wb_data = sext_imm; end
          5'b01001: begin wb_en = 1'b1; wb_data = zext_imm; end
          5'b01010: begin wb_en = 1'b1; wb_data = hi_imm; end
          5'b01100: begin wb_en = 1'b1; wb_data = a + sext_imm; end
          5'b01101: begin wb_en = 1'b1; wb_data = a + zext_imm; end
          5'b10000: if (a == '0) pc_exec = pc + sext_imm;
          5'b10001: if (a != '0) pc_exec = pc + sext_imm;
          5'b10101: pc_exec = pc + sext_off;
`ifdef POCO_MC_JAL_EN
          5'b10110: begin
            pc_exec = pc + sext_off;
            wb_en   = 1'b1;
            wb_idx  = 3'd7;
            wb_data = pc;
          end
`endif
          default: ;
        endcase
      end
      MEM: begin
        if (bus.dack) begin
          state_nx = FETCH;
          wb_en    = ~dwe_q;
          wb_data  = bus.ddatain;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // pc, instruction register and registered bus outputs; reset overrides any handshake in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      ireq_q     <= 1'b1;
      dreq_q     <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      ddataout_q <= '0;
      retire     <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (bus.iack) begin
            ir     <= bus.idatain;
            pc     <= pc + DATA_W'(1);
            ireq_q <= 1'b0;
          end
        end
        EXEC: begin
          pc <= pc_exec;
          if (mem_go) begin
            daddr_q    <= b;
            ddataout_q <= a;
            dwe_q      <= mem_we;
            dreq_q     <= 1'b1;
          end else begin
            retire <= 1'b1;
            ireq_q <= 1'b1;
          end
        end
        MEM: begin
          if (bus.dack) begin
            dreq_q <= 1'b0;
            dwe_q  <= 1'b0;
            retire <= 1'b1;
            ireq_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file write port; contents survive reset, but a reset edge cancels the write
  always_ff @(posedge clk) begin
    if (!rst && wb_en && int'(wb_idx) < RF_DEPTH) rf[wb_idx] <= wb_data;
  end

endmodule

// File: tb/tb_poco_mc.sv
// tb/tb_poco_mc.sv - instruction-level reference model and cycle checker for poco_mc
module tb_poco_mc;
  localparam int DW  = 16;
  localparam int RFD = 8;
`ifdef POCO_MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif
  localparam int LIT_JAL_PC = JAL_EN ? 'h31 : 'h21;
  localparam int LIT_R7     = JAL_EN ? 'h21 : 'h77;

  localparam logic [4:0] OP_LDI   = 5'b01000;
  localparam logic [4:0] OP_LDIU  = 5'b01001;
  localparam logic [4:0] OP_LDHI  = 5'b01010;
  localparam logic [4:0] OP_ADDIU = 5'b01101;
  localparam logic [4:0] OP_BEZ   = 5'b10000;
  localparam logic [4:0] OP_BNZ   = 5'b10001;
  localparam logic [4:0] OP_JAL   = 5'b10110;
  localparam logic [4:0] FN_ST    = 5'b01000;
  localparam logic [4:0] FN_LD    = 5'b01001;
  localparam logic [4:0] FN_JR    = 5'b01100;

  logic clk = 1'b0;
  logic rst;
  logic retire;

  poco_mc_if #(.DATA_W(DW)) bus ();

  poco_mc #(.DATA_W(DW), .RF_DEPTH(RFD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .retire (retire)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit exp_valid = 1'b0;
  bit exp_ireq, exp_dreq, exp_retire, exp_dwe, exp_dz;
  int exp_iaddr, exp_daddr, exp_dout;

  int m_rf [8];
  int m_pc = 0;
  bit ret_pend = 1'b0;
  bit after_rst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Every cycle: DUT bus outputs against what the instruction-level model says they must be
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("ireq",   32'(bus.ireq), 32'(exp_ireq));
      chk("dreq",   32'(bus.dreq), 32'(exp_dreq));
      chk("retire", 32'(retire),   32'(exp_retire));
      if (exp_ireq) chk("iaddr", 32'(bus.iaddr), exp_iaddr);
      if (exp_dreq) begin
        chk("daddr",    32'(bus.daddr),    exp_daddr);
        chk("ddataout", 32'(bus.ddataout), exp_dout);
        chk("dwe",      32'(bus.dwe),      32'(exp_dwe));
      end
      if (exp_dz) begin
        chk("rst_daddr",    32'(bus.daddr),    0);
        chk("rst_ddataout", 32'(bus.ddataout), 0);
        chk("rst_dwe",      32'(bus.dwe),      0);
      end
    end
  end

  function automatic int rget(input int idx);
    return (idx < RFD) ? m_rf[idx] : 0;
  endfunction

  task automatic rset(input int idx, input int v);
    if (idx < RFD) m_rf[idx] = v & 'hFFFF;
  endtask

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int sx11(input int v);
    return (v >= 1024) ? v - 2048 : v;
  endfunction

  // Architectural effect of one instruction; loads are completed by the caller
  task automatic model_exec(input logic [15:0] w, output bit is_mem, output bit we,
                            output int ea, output int sd, output int ld_rd);
    int op, rd, rs, fn, imm, off, a, b, pc1, r;
    op  = int'(w[15:11]);
    rd  = int'(w[10:8]);
    rs  = int'(w[7:5]);
    fn  = int'(w[4:0]);
    imm = int'(w[7:0]);
    off = int'(w[10:0]);
    a   = rget(rd);
    b   = rget(rs);
    pc1 = (m_pc + 1) % 65536;
    is_mem = 1'b0; we = 1'b0; ea = 0; sd = 0; ld_rd = rd;
    m_pc = pc1;
    case (op)
      0: begin
        if (fn < 8) begin
          case (fn)
            2: r = a | b;
            3: r = a & b;
            4: r = a * 2;
            5: r = a / 2;
            6: r = a + b;
            7: r = a - b + 65536;
            default: r = b;
          endcase
          rset(rd, r);
        end else if (fn == 8 || fn == 9) begin
          is_mem = 1'b1; we = (fn == 8); ea = b; sd = a;
        end else if (fn == 12) begin
          m_pc = a;
        end else if (fn == 24 && JAL_EN) begin
          rset(7, pc1); m_pc = a;
        end
      end
      8:  rset(rd, (imm >= 128) ? imm + 65280 : imm);
      9:  rset(rd, imm);
      10: rset(rd, imm * 256);
      12: rset(rd, a + sx8(imm) + 65536);
      13: rset(rd, a + imm);
      16: if (a == 0) m_pc = (pc1 + sx8(imm) + 65536) % 65536;
      17: if (a != 0) m_pc = (pc1 + sx8(imm) + 65536) % 65536;
      21: m_pc = (pc1 + sx11(off) + 65536) % 65536;
      22: if (JAL_EN) begin rset(7, pc1); m_pc = (pc1 + sx11(off) + 65536) % 65536; end
      default: ;
    endcase
  endtask

  // Drive one instruction through fetch / exec / optional mem, stating the expected outputs per cycle
  task automatic do_instr(input logic [15:0] w, input int ldv, input int idly, input int ddly,
                          input int lit_iaddr, input int lit_daddr, input int lit_dout,
                          input bit rst_in_mem);
    bit is_mem, we;
    int ea, sd, ld_rd;
    for (int i = 0; i <= idly; i++) begin
      bus.iack    = (i == idly);
      bus.idatain = (i == idly) ? w : 16'($urandom);
      exp_ireq    = 1'b1;
      exp_dreq    = 1'b0;
      exp_iaddr   = m_pc;
      exp_retire  = (i == 0) ? ret_pend : 1'b0;
      exp_dz      = (i == 0) ? after_rst : 1'b0;
      if (i == 0 && lit_iaddr >= 0) chk("lit_iaddr", 32'(bus.iaddr), lit_iaddr);
      @(posedge clk); #1;
    end
    ret_pend = 1'b0;
    after_rst = 1'b0;
    bus.iack = 1'b0;
    model_exec(w, is_mem, we, ea, sd, ld_rd);
    exp_ireq = 1'b0; exp_dreq = 1'b0; exp_retire = 1'b0; exp_dz = 1'b0;
    @(posedge clk); #1;
    if (is_mem) begin
      for (int i = 0; i <= ddly; i++) begin
        bus.dack    = (i == ddly);
        bus.ddatain = (i == ddly) ? 16'(ldv) : 16'($urandom);
        rst         = rst_in_mem && (i == ddly);
        exp_dreq    = 1'b1;
        exp_daddr   = ea;
        exp_dout    = sd;
        exp_dwe     = we;
        if (i == 0 && lit_daddr >= 0) chk("lit_daddr", 32'(bus.daddr), lit_daddr);
        if (i == 0 && lit_dout >= 0)  chk("lit_dout", 32'(bus.ddataout), lit_dout);
        @(posedge clk); #1;
      end
      bus.dack = 1'b0;
      rst = 1'b0;
      exp_dreq = 1'b0;
      if (rst_in_mem) begin
        m_pc = 0;
        after_rst = 1'b1;
      end else begin
        if (!we) rset(ld_rd, ldv);
        ret_pend = 1'b1;
      end
    end else begin
      ret_pend = 1'b1;
    end
  endtask

  task automatic di(input logic [15:0] w, input int lit_iaddr);
    do_instr(w, 0, 0, 0, lit_iaddr, -1, -1, 1'b0);
  endtask

  // Hold reset n cycles starting from an idle fetch cycle, optionally with iack raised
  task automatic reset_pulse(input int n, input bit iack_val, input bit chk_first);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      bus.iack = iack_val;
      bus.idatain = 16'($urandom);
      bus.dack = 1'b0;
      exp_ireq = 1'b1;
      exp_dreq = 1'b0;
      if (i == 0) begin
        exp_valid = chk_first; exp_iaddr = m_pc; exp_retire = ret_pend; exp_dz = after_rst;
      end else begin
        exp_valid = 1'b1; exp_iaddr = 0; exp_retire = 1'b0; exp_dz = 1'b1;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.iack = 1'b0;
    m_pc = 0;
    ret_pend = 1'b0;
    after_rst = 1'b1;
    exp_valid = 1'b1;
  endtask

  function automatic logic [15:0] ei(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [15:0] er(input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] fn);
    return {5'b00000, rd, rs, fn};
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [2:0]  rd, rs, f3;
    logic [7:0]  imm;
    logic [10:0] off;
    rd  = 3'($urandom);
    rs  = 3'($urandom);
    f3  = 3'($urandom);
    imm = 8'($urandom);
    off = 11'($urandom);
    case ($urandom_range(0, 9))
      0, 1: return {5'b00000, rd, rs, 2'b00, f3};
      2: return ei(OP_LDI, rd, imm);
      3: case ($urandom_range(0, 3))
           0: return ei(OP_LDIU, rd, imm);
           1: return ei(5'b01100, rd, imm);
           2: return ei(OP_ADDIU, rd, imm);
           default: return ei(OP_LDHI, rd, imm);
         endcase
      4: return er(rd, rs, FN_ST);
      5: return er(rd, rs, FN_LD);
      6: return {4'b1000, 1'($urandom), rd, imm};
      7: return ($urandom_range(0, 1) == 0) ? {5'b10101, off} : {OP_JAL, off};
      8: return ($urandom_range(0, 1) == 0) ? er(rd, rs, FN_JR) : er(rd, rs, 5'b11000);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.iack = 1'b0; bus.idatain = '0; bus.dack = 1'b0; bus.ddatain = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;

    reset_pulse(2, 1'b0, 1'b0);

    di(ei(OP_LDI, 3'd1, 8'hFF), 0);
    di(ei(OP_ADDIU, 3'd1, 8'h02), 1);
    di(ei(OP_LDI, 3'd2, 8'h10), -1);
    do_instr(er(3'd1, 3'd2, FN_ST), 0, 0, 0, -1, 'h10, 'h0001, 1'b0);

    di(ei(OP_LDHI, 3'd1, 8'h12), -1);
    di(ei(OP_ADDIU, 3'd1, 8'h34), -1);
    do_instr(er(3'd1, 3'd2, FN_ST), 0, 0, 3, -1, 'h10, 'h1234, 1'b0);
    do_instr(er(3'd3, 3'd2, FN_LD), 'hBEEF, 1, 1, -1, 'h10, -1, 1'b0);
    do_instr(er(3'd3, 3'd2, FN_ST), 0, 0, 0, -1, -1, 'hBEEF, 1'b0);

    di(ei(OP_LDI, 3'd0, 8'h00), -1);
    di(ei(OP_LDI, 3'd4, 8'h05), -1);
    di(er(3'd4, 3'd0, FN_JR), -1);
    di(ei(OP_BEZ, 3'd0, 8'hFC), 5);
    di(er(3'd4, 3'd0, FN_JR), 2);
    di(ei(OP_BNZ, 3'd0, 8'hFC), 5);
    di(ei(OP_LDI, 3'd7, 8'h77), 6);

    di(ei(OP_LDI, 3'd5, 8'h20), -1);
    di(er(3'd5, 3'd0, FN_JR), -1);
    di({OP_JAL, 11'h010}, 'h20);
    do_instr(er(3'd7, 3'd2, FN_ST), 0, 0, 0, LIT_JAL_PC, -1, LIT_R7, 1'b0);

    di(ei(OP_LDI, 3'd4, 8'hFF), -1);
    di(er(3'd4, 3'd0, FN_JR), -1);
    di(16'hF800, 'hFFFF);
    di(ei(OP_LDI, 3'd6, 8'h55), 0);
    do_instr(er(3'd6, 3'd2, FN_LD), 'hAAAA, 0, 2, -1, 'h10, -1, 1'b1);
    do_instr(er(3'd6, 3'd2, FN_ST), 0, 0, 0, 0, 'h10, 'h0055, 1'b0);

    di(ei(OP_LDI, 3'd6, 8'h33), -1);
    reset_pulse(1, 1'b1, 1'b1);
    di(16'hF800, 0);

    for (int k = 0; k < 400; k++) begin
      do_instr(rand_instr(), int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), -1, -1, -1, 1'b0);
    end
    for (int k = 0; k < 8; k++) di(er(3'(k), 3'd2, FN_ST), -1);
    di(16'hF800, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poco_mc.md
POCO_MC -- requirements
Module: poco_mc

Interface
REQ-001 Parameter DATA_W, default 16, datapath/register/address width; legal values 16..32.
REQ-002 Parameter RF_DEPTH, default 8, number of registers; legal values 2..8, addressed by instruction rd/rs fields.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port iaddr  output  DATA_W  instruction address (=pc).
REQ-006 Port ireq  output  1  instruction fetch request, registered.
REQ-007 Port iack  input  1  fetch acknowledge; idatain valid same cycle.
REQ-008 Port idatain  input  16  instruction word {opcode[15:11], rd[10:8], rs[7:5], func[4:0]}; imm=[7:0].
REQ-009 Port daddr  output  DATA_W  data address (=rf[rs]), registered.
REQ-010 Port ddataout  output  DATA_W  store data (=rf[rd]), registered.
REQ-011 Port dreq  output  1  data request, registered.
REQ-012 Port dwe  output  1  write enable, qualifies dreq.
REQ-013 Port dack  input  1  data acknowledge; ddatain valid same cycle for loads.
REQ-014 Port ddatain  input  DATA_W  load data.
REQ-015 Port retire  output  1  one-cycle pulse when an instruction completes.

Function
REQ-016 FSM states FETCH, EXEC, MEM; reset state FETCH.
REQ-017 FETCH: ireq=1 held until iack; on iack latch idatain into ir, pc<=pc+1, ireq<=0, go EXEC.
REQ-018 EXEC: decode ir; ALU/immediate ops write rd, pulse retire, go FETCH (2-cycle minimum instruction latency).
REQ-019 ALU ops: opcode 00000, func[4:3]=00, func[2:0]: 000 THB (y=b), 010 OR, 011 AND, 100 SL (a<<1), 101 SR (a>>1 logical), 110 ADD, 111 SUB; 001 reserved -> THB; a=rf[rd], b=rf[rs].
REQ-020 Immediates: LDI 01000 sign-extend imm; LDIU 01001 zero-extend; ADDI 01100 rd+sext; ADDIU 01101 rd+zext; LDHI 01010 rd<=imm<<8 zero-extended to DATA_W.
REQ-021 Arithmetic wraps modulo 2^DATA_W; no flags.
REQ-022 ST (opcode 00000, func 01000) / LD (func 01001): EXEC loads daddr, ddataout, dwe, dreq<=1, go MEM.
REQ-023 MEM: hold dreq and all data outputs until dack; on dack dreq<=0, LD writes ddatain to rd, pulse retire, go FETCH (3-cycle minimum).
REQ-024 BEZ 10000 / BNZ 10001: if rf[rd]==0 / !=0 then pc<=pc+sext(imm) (pc already incremented); retire, go FETCH.
REQ-025 JMP 10101: pc<=pc+sext(ir[10:0]); JR (opcode 00000, func 01100): pc<=rf[rd].
REQ-026 Undefined encodings execute as NOP: no register, pc-only increment, retire pulsed.
REQ-027 Register index >= RF_DEPTH reads 0, writes discarded.
REQ-028 At most one of ireq/dreq asserted in any cycle.
REQ-029 pc wraps from 2^DATA_W-1 to 0.

Reset
REQ-030 rst at any edge, any state (incl. mid-handshake): next state FETCH, pc=0, ir=0, ireq=1 after the reset edge, dreq=0, dwe=0, daddr=0, ddataout=0, retire=0.
REQ-031 iack/dack sampled in the same cycle as rst are ignored.
REQ-032 Register file contents unaffected by reset (undefined at power-up).

Configuration
REQ-033 Macro POCO_MC_JAL_EN: when defined, JAL opcode 10110 sets r7<=pc (return address), pc<=pc+sext(ir[10:0]); JALR (opcode 00000, func 11000) sets r7<=pc, pc<=rf[rd]; both retire in EXEC.
REQ-034 Without POCO_MC_JAL_EN, 10110 and JALR execute as NOP per REQ-026; r7 untouched.

Verification
REQ-035 rst high 2 cycles, release -> iaddr=0, ireq=1, dreq=0, retire=0.
REQ-036 Memory: LDI r1,0xFF; ADDIU r1,0x02 (iack immediate) -> r1=0x0001, retire every 2nd cycle.
REQ-037 r2=0x0010, r1=0x1234; ST r1,(r2) with dack delayed 3 cycles -> daddr=0x0010, ddataout=0x1234, dwe=1 stable until dack; LD r3,(r2) returns 0xBEEF -> r3=0xBEEF.
REQ-038 r0=0 at pc=5, BEZ r0,0xFC -> next iaddr=0x0002; BNZ same -> iaddr=0x0006.
REQ-039 rst asserted during MEM with dack same cycle -> register unchanged, dreq=0 next cycle, iaddr=0.
REQ-040 With POCO_MC_JAL_EN, JAL +0x010 at pc=0x20 -> r7=0x0021, iaddr=0x0031; without it -> iaddr=0x0021, r7 unchanged.
